// File: rtl/rr_mux_stream_pkg.sv
// Shared definitions for the N-channel streaming mux: mode encodings and bus-slicing helpers.
// No logic of its own; imported by the arbiter and the top.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // LSB position of channel i on a packed bus of w-bit lanes; use as bus[chan_lsb(i, w) +: w].
    function automatic int chan_lsb(input int i, input int w);
        return i * w;
    endfunction

    // Wrap an index into 0..n-1 after a step of +1 (pointer advance).
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/rr_mux_stream_arbiter.sv
// Combinational N-way arbiter: fixed priority (lowest index) or round-robin from ptr+1.
// Latency: zero (purely combinational).
// Backpressure: none here; the caller gates grant with its load condition.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot_dbl;
    logic [N-1:0]   req_rot;
    logic           found;
    int             start_idx;
    int             win_idx;

    // Rotating the doubled request vector puts the search start at bit 0,
    // so a single lowest-set-bit search covers the full wrap.
    always_comb begin
        start_idx   = 0;
        win_idx     = 0;
        found       = 1'b0;
        grant       = '0;
        grant_idx   = '0;
        if (mode == MODE_RR) begin
            start_idx = wrap_inc(int'(ptr), N);
        end
        req_dbl     = {req, req};
        req_rot_dbl = req_dbl >> start_idx;
        req_rot     = req_rot_dbl[N-1:0];
        for (int j = 0; j < N; j++) begin
            if (req_rot[j] && !found) begin
                found   = 1'b1;
                win_idx = (start_idx + j) % N;
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
            grant_idx      = SEL_W'(win_idx);
        end
    end

endmodule

// File: rtl/rr_mux_stream.sv
// N-channel valid/ready stream mux with runtime fixed-priority or round-robin arbitration.
// Latency: one cycle from accepted input beat to out_valid; one beat per cycle while out_ready=1.
// Backpressure: when the output register holds a beat and out_ready=0, all in_ready drop and state holds.
module rr_mux_stream
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic             xfer;

    logic             out_valid_d, out_valid_q;
    logic [W-1:0]     out_data_d,  out_data_q;
    logic [SEL_W-1:0] out_sel_d,   out_sel_q;
    logic [SEL_W-1:0] ptr_d,       ptr_q;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load = ~out_valid_q | out_ready;
    assign xfer = load & (|grant);

    // Reset gating keeps producers from seeing a handshake that the flops will ignore.
    always_comb begin
        in_ready = '0;
        if (load && !rst) begin
            in_ready = grant;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = xfer;
        end
        // ptr tracks the last grant in both modes so a switch to round-robin resumes fairly.
        if (xfer) begin
            out_data_d = in_data[chan_lsb(int'(grant_idx), W) +: W];
            out_sel_d  = grant_idx;
            ptr_d      = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SEL_W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed plus random bench for rr_mux_stream at N=4 and N=5 (W=8) against a queue-free
// behavioural model that searches channels by plain modular arithmetic.
module tb_rr_mux_stream;

    logic        clk;
    logic        rst;
    logic        md;
    logic        ordy;
    logic [31:0] v;
    logic [7:0]  d [5];
    int          cur_n;

    logic [31:0] in_data4;
    logic [3:0]  ir4;
    logic [7:0]  od4;
    logic [1:0]  os4;
    logic        ov4;

    logic [39:0] in_data5;
    logic [4:0]  ir5;
    logic [7:0]  od5;
    logic [2:0]  os5;
    logic        ov5;

    logic        o_v;
    logic [31:0] o_d, o_s, o_r;

    logic        m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    int          m_ptr;

    int errs   = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_data4 = '0;
        in_data5 = '0;
        for (int i = 0; i < 4; i++) in_data4[i*8 +: 8] = d[i];
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = d[i];
    end

    rr_mux_stream #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .mode(md), .in_data(in_data4), .in_valid(v[3:0]),
        .in_ready(ir4), .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(ordy)
    );

    rr_mux_stream #(.N(5), .W(8)) dut5 (
        .clk(clk), .rst(rst), .mode(md), .in_data(in_data5), .in_valid(v[4:0]),
        .in_ready(ir5), .out_data(od5), .out_sel(os5), .out_valid(ov5), .out_ready(ordy)
    );

    always_comb begin
        if (cur_n == 4) begin
            o_v = ov4; o_d = 32'(od4); o_s = 32'(os4); o_r = 32'(ir4);
        end else begin
            o_v = ov5; o_d = 32'(od5); o_s = 32'(os5); o_r = 32'(ir5);
        end
    end

    // Winner by the rules: lowest valid index, or first valid after p going upward with wrap.
    function automatic int pick(input int n, input logic [31:0] vv, input logic mode_rr, input int p);
        if (!mode_rr) begin
            for (int i = 0; i < n; i++) if (vv[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) if (vv[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_ptr   = cur_n - 1;
    endtask

    // Reset edge without comparison, used where the checked instance changes.
    task automatic raw_reset();
        @(posedge clk);
        model_reset();
        #1;
    endtask

    task automatic cycle();
        int          g;
        logic        ld;
        logic [31:0] er;
        @(negedge clk);
        ld = !m_valid || ordy;
        g  = pick(cur_n, v, md, m_ptr);
        er = (rst || !ld || g < 0) ? 32'd0 : (32'd1 << g);
        chk("out_valid", 32'(o_v), 32'(m_valid));
        chk("out_data",  o_d, 32'(m_data));
        chk("out_sel",   o_s, 32'(m_sel));
        chk("in_ready",  o_r, er);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d[g];
                m_sel   = g;
                m_ptr   = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        cur_n = 4;
        rst   = 1'b1;
        md    = 1'b1;
        ordy  = 1'b1;
        v     = 32'h1f;
        for (int i = 0; i < 5; i++) d[i] = 8'(8'h10 + i);
        model_reset();

        // Reset held with every channel requesting
        raw_reset();
        cycle();
        cycle();
        chk("rst_valid", 32'(o_v), 32'd0);
        chk("rst_ready", o_r, 32'd0);
        chk("rst_data",  o_d, 32'd0);

        // Round-robin over all four channels
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_sel",  o_s, 32'(rr_exp[i]));
            chk("rr_data", o_d, 32'(8'h10 + rr_exp[i]));
            chk("rr_vld",  32'(o_v), 32'd1);
        end

        // Fixed priority with channels 1 and 2 requesting
        md = 1'b0;
        v  = 32'b0110;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fix_sel",  o_s, 32'd1);
            chk("fix_data", o_d, 32'h11);
            chk("fix_ir2",  32'(o_r[2]), 32'd0);
        end

        // Backpressure on a beat from channel 2
        v = 32'b0100;
        cycle();
        chk("bp_first", o_s, 32'd2);
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_sel",   o_s, 32'd2);
            chk("bp_data",  o_d, 32'h12);
            chk("bp_vld",   32'(o_v), 32'd1);
            chk("bp_ready", o_r, 32'd0);
        end
        ordy = 1'b1;
        d[2] = 8'h5a;
        cycle();
        chk("bp_next", o_d, 32'h5a);
        d[2] = 8'h12;

        // Wrap from ptr=3 and sparse requests
        md = 1'b1;
        v  = 32'b1000;
        cycle();
        chk("wrap_3", o_s, 32'd3);
        v = 32'b0100;
        cycle();
        chk("wrap_2", o_s, 32'd2);
        cycle();
        chk("self_2", o_s, 32'd2);
        v = 32'b0101;
        cycle();
        chk("sparse_0", o_s, 32'd0);
        cycle();
        chk("sparse_2", o_s, 32'd2);
        v = 32'b0000;
        cycle();
        chk("drain_vld",  32'(o_v), 32'd0);
        chk("drain_data", o_d, 32'h12);

        // Random traffic on N=4
        for (int t = 0; t < 300; t++) begin
            v    = 32'($urandom_range(0, 15));
            md   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 40) == 0);
            for (int i = 0; i < 5; i++) d[i] = 8'($urandom_range(0, 255));
            cycle();
        end

        // N=5: mid-stream reset and index range
        cur_n = 5;
        rst   = 1'b1;
        md    = 1'b1;
        ordy  = 1'b1;
        v     = 32'h1f;
        for (int i = 0; i < 5; i++) d[i] = 8'(8'h20 + i);
        raw_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("n5_vld", 32'(o_v), 32'd1);
        rst = 1'b1;
        cycle();
        chk("n5_rst_vld", 32'(o_v), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            cycle();
            chk("n5_sel_range", 32'(o_s < 32'd5), 32'd1);
            chk("n5_rot", o_s, 32'(i % 5));
        end

        // Random traffic on N=5
        for (int t = 0; t < 300; t++) begin
            v    = 32'($urandom_range(0, 31));
            md   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 40) == 0);
            for (int i = 0; i < 5; i++) d[i] = 8'($urandom_range(0, 255));
            cycle();
            chk("n5_rand_range", 32'(o_s < 32'd5), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
